// File: rtl/jtgng_prom_pkg.sv
// rtl/jtgng_prom_pkg.sv - shared state encoding and address-window helper for the PROM loader
package jtgng_prom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Exclusive end of the download window covering all PROMs
  function automatic logic [63:0] win_end(input logic [63:0] start, input int nprom, input int aw);
    return start + (64'(nprom) << aw);
  endfunction

endpackage

// File: rtl/jtgng_prom_loader.sv
// rtl/jtgng_prom_loader.sv - decodes the ioctl download stream into one-hot writes for a bank of PROMs
module jtgng_prom_loader
  import jtgng_prom_pkg::*;
#(
  parameter int              aw    = 10,
  parameter int              dw    = 8,
  parameter int              NPROM = 4,
  parameter int              IOAW  = 22,
  parameter logic [IOAW-1:0] START = 22'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             downloading,
  input  logic [IOAW-1:0]  ioctl_addr,
  input  logic [7:0]       ioctl_data,
  input  logic             ioctl_wr,
  output logic [NPROM-1:0] prom_we,
  output logic [aw-1:0]    prom_addr,
  output logic [dw-1:0]    prom_data,
  output logic [NPROM-1:0] prom_ok,
  output logic             busy,
  output logic             done
);

  localparam int KW = (NPROM > 1) ? $clog2(NPROM) : 1;
  localparam logic [IOAW:0] WEND = (IOAW+1)'(win_end(64'(START), NPROM, aw));

  state_t            state;
  logic              dl_q;
  logic [15:0]       cnt;
  logic [IOAW-1:0]   offset;
  logic [KW-1:0]     idx;
  logic [NPROM-1:0]  we_vec;
  logic              in_win;
  logic              dl_rise;
  logic              accept;

  always_comb begin
    offset  = ioctl_addr - START;
    idx     = KW'(offset >> aw);
    we_vec  = NPROM'(1) << idx;
    in_win  = (ioctl_addr >= START) && ({1'b0, ioctl_addr} < WEND);
    dl_rise = downloading & ~dl_q;
    accept  = ioctl_wr & downloading & in_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      // Reset high so a session already running at reset release is not taken as a new edge
      dl_q      <= 1'b1;
      cnt       <= '0;
      prom_we   <= '0;
      prom_addr <= '0;
      prom_data <= '0;
      prom_ok   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      dl_q    <= downloading;
      prom_we <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (dl_rise) begin
            state   <= ST_LOAD;
            prom_ok <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!downloading) begin
            state <= ST_FLUSH;
          end else if (accept) begin
            prom_we   <= we_vec;
            prom_addr <= offset[aw-1:0];
            prom_data <= ioctl_data[dw-1:0];
            if (&offset[aw-1:0]) prom_ok <= prom_ok | we_vec;
            if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
          end
        end
        ST_FLUSH: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtgng_prom_loader.sv
// tb/tb_jtgng_prom_loader.sv - scoreboard bench for the PROM download loader
module tb_jtgng_prom_loader;

  localparam int AW = 8;
  localparam int NP = 4;
  localparam logic [21:0] ST = 22'h1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          downloading = 1'b1;
  logic [21:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_data = '0;
  logic          ioctl_wr = 1'b0;
  logic [NP-1:0] prom_we;
  logic [AW-1:0] prom_addr;
  logic [7:0]    prom_data;
  logic [NP-1:0] prom_ok;
  logic          busy;
  logic          done;

  jtgng_prom_loader #(.aw(AW), .dw(8), .NPROM(NP), .IOAW(22), .START(ST)) dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .prom_we(prom_we), .prom_addr(prom_addr),
    .prom_data(prom_data), .prom_ok(prom_ok), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] we;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         passed = 0;
  int         we_count = 0;
  logic [7:0] dmem [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] we, input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.we = we; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && prom_we != '0) begin
      we_count++;
      for (int k = 0; k < NP; k++)
        if (prom_we[k]) dmem[k*256 + int'(prom_addr)] = prom_data;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_we: got we=%b addr=%h data=%h expected no write", prom_we, prom_addr, prom_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write", {12'h0, prom_we, prom_addr, prom_data}, {12'h0, e.we, e.addr, e.data});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with downloading already high
    tick(); tick();
    chk("rst_we", 32'(prom_we), 0);
    chk("rst_ok_busy_done", {prom_ok, busy, done}, 0);
    chk("rst_addr_data", {prom_addr, prom_data}, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("no_edge_idle", 32'(dut.state), 0);

    // Rising edge starts LOAD
    downloading = 1'b0; tick();
    downloading = 1'b1; tick();
    chk("load_state", 32'(dut.state), 1);
    chk("load_busy", {busy, done}, 2'b10);

    // Single write, one-cycle latency
    ioctl_addr = 22'h1105; ioctl_data = 8'hA5; ioctl_wr = 1'b1;
    push(4'b0010, 8'h05, 8'hA5);
    tick();
    ioctl_wr = 1'b0;
    chk("single_we", 32'(prom_we), 32'b0010);
    chk("single_addr_data", {prom_addr, prom_data}, 16'h05A5);
    tick();
    chk("single_we_drop", 32'(prom_we), 0);
    chk("single_hold", {prom_addr, prom_data}, 16'h05A5);

    // Window edges
    ioctl_wr = 1'b1;
    ioctl_addr = 22'h0FFF; ioctl_data = 8'h11; tick();
    ioctl_addr = 22'h1400; ioctl_data = 8'h22; tick();
    chk("below_above_no_we", 32'(prom_we), 0);
    ioctl_addr = 22'h13FF; ioctl_data = 8'h77;
    push(4'b1000, 8'hFF, 8'h77);
    tick();
    ioctl_wr = 1'b0;
    chk("top_we", {prom_we, prom_addr}, {4'b1000, 8'hFF});
    chk("top_ok", 32'(prom_ok), 32'b1000);
    chk("cnt_two", 32'(dut.cnt), 2);
    tick();

    // Strobe in the cycle downloading falls is ignored
    downloading = 1'b0; ioctl_wr = 1'b1; ioctl_addr = 22'h1200; ioctl_data = 8'h33;
    tick();
    ioctl_wr = 1'b0;
    chk("fall_no_we", 32'(prom_we), 0);
    chk("flush_state", {30'h0, dut.state}, 2);
    chk("flush_busy", {busy, done}, 2'b10);
    tick();
    chk("done_state", {30'h0, dut.state}, 3);
    chk("done_flags", {busy, done}, 2'b01);
    chk("done_cnt", 32'(dut.cnt), 2);
    tick();

    // Restart from DONE and full load
    downloading = 1'b1; tick();
    chk("restart_flags", {prom_ok, busy, done}, 6'b000010);
    chk("restart_cnt", 32'(dut.cnt), 0);
    we_count = 0;
    for (int i = 0; i < 1024; i++) begin
      ioctl_addr = ST + 22'(i); ioctl_data = 8'(i); ioctl_wr = 1'b1;
      push(4'(1 << (i / 256)), 8'(i), 8'(i));
      tick();
      if (i == 255) chk("ok_after_prom0", 32'(prom_ok), 32'b0001);
    end
    ioctl_wr = 1'b0; downloading = 1'b0;
    tick();
    chk("full_flush_busy", {busy, done}, 2'b10);
    tick();
    chk("full_done", {busy, done}, 2'b01);
    chk("full_ok", 32'(prom_ok), 32'hF);
    chk("full_cnt", 32'(dut.cnt), 1024);
    chk("full_we_count", 32'(we_count), 1024);
    chk("queue_empty", 32'(exp_q.size()), 0);
    for (int i = 0; i < 1024; i++)
      if (dmem[i] !== 8'(i)) chk("mem", {24'h0, dmem[i]}, 32'(i[7:0]));
    checks++; passed++;

    // Reset in the middle of a load
    tick();
    downloading = 1'b1; tick();
    chk("reload_state", {30'h0, dut.state}, 1);
    for (int i = 0; i < 10; i++) begin
      ioctl_addr = 22'h1100 + 22'(i); ioctl_data = 8'hC0 + 8'(i); ioctl_wr = 1'b1;
      push(4'b0010, 8'(i), 8'hC0 + 8'(i));
      tick();
    end
    chk("mid_cnt", 32'(dut.cnt), 10);
    chk("mid_we", 32'(prom_we), 32'b0010);
    rst = 1'b1; ioctl_wr = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_we", 32'(prom_we), 0);
    chk("mid_rst_cnt", 32'(dut.cnt), 0);
    chk("mid_rst_state", {30'h0, dut.state}, 0);
    chk("mid_rst_flags", {prom_ok, busy, done, prom_addr, prom_data}, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_idle", {30'h0, dut.state}, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
